bilinear_sample_ctrl: RTL and testbench

Sequencer for deformable-convolution bilinear sampling. Accepts one sampling request (integer base pixel plus signed fixed-point offset), converts it to a clipped integer base and fractional weights, and issues four tap reads to the tile buffer. It then accumulates the weighted taps and returns one interpolated pixel over a valid/ready handshake. It sits between the offset-generation stage and the deformable-conv MAC array and owns the tile-buffer read port.

---
 rtl/bilinear_sample_ctrl_if.sv | 34 +++
 rtl/bilinear_sample_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bilinear_sample_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bilinear_sample_ctrl_if.sv
// Request, tile-buffer read and result signals of bilinear_sample_ctrl.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface bilinear_sample_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4,
   parameter int PIX_W  = 16
);
   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] req_off_x;
   logic [DATA_W-1:0] req_off_y;
   logic [IDX_W-1:0]  req_base_x0;
   logic [IDX_W-1:0]  req_base_y0;
   logic              mem_rd_en;
   logic [IDX_W-1:0]  mem_rd_x;
   logic [IDX_W-1:0]  mem_rd_y;
   logic [PIX_W-1:0]  mem_rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [PIX_W-1:0]  out_data;
   logic              busy;

   modport slave (
      input  req_valid, req_off_x, req_off_y, req_base_x0, req_base_y0,
      input  mem_rd_data, out_ready,
      output req_ready, mem_rd_en, mem_rd_x, mem_rd_y, out_valid, out_data, busy
   );

   modport master (
      output req_valid, req_off_x, req_off_y, req_base_x0, req_base_y0,
      output mem_rd_data, out_ready,
      input  req_ready, mem_rd_en, mem_rd_x, mem_rd_y, out_valid, out_data, busy
   );
endinterface

// File: rtl/bilinear_sample_ctrl.sv
// Bilinear sampling sequencer: fixed-point offset request -> four tap reads -> one weighted pixel.
// Build macro BSC_ZERO_PAD_EN: out-of-tile taps contribute zero instead of clamping the base.
module bilinear_sample_ctrl #(
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 8,
   parameter int IDX_W     = 4,
   parameter int MAX_X     = 16,
   parameter int MAX_Y     = 16,
   parameter int PIX_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   bilinear_sample_ctrl_if.slave bus,
   output logic [1:0]            state_dbg
);
   localparam int INT_W = DATA_W - FRAC_BITS;
   localparam int CRD_W = INT_W + 1;
   localparam int WU_W  = 2*FRAC_BITS + 2;
   localparam int ACC_W = PIX_W + 2*FRAC_BITS + 3;
   localparam int RES_W = ACC_W - 2*FRAC_BITS;

   localparam logic [FRAC_BITS:0]       S_ONE = {1'b1, {FRAC_BITS{1'b0}}};
   localparam logic signed [CRD_W-1:0]  X_HI  = CRD_W'(MAX_X - 1);
   localparam logic signed [CRD_W-1:0]  Y_HI  = CRD_W'(MAX_Y - 1);
   localparam logic signed [ACC_W-1:0]  RND   =
      {{(ACC_W-2*FRAC_BITS){1'b0}}, 1'b1, {(2*FRAC_BITS-1){1'b0}}};
   localparam logic signed [RES_W-1:0]  P_MAX = {{(RES_W-PIX_W+1){1'b0}}, {(PIX_W-1){1'b1}}};
   localparam logic signed [RES_W-1:0]  P_MIN = {{(RES_W-PIX_W+1){1'b1}}, {(PIX_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;
   state_t state_q, state_d;

   logic                    accept;
   logic [DATA_W-1:0]       sum_x, sum_y;
   logic signed [CRD_W-1:0] int_x, int_y, base_x, base_y;
   logic signed [CRD_W-1:0] bx_q, by_q;
   logic [FRAC_BITS-1:0]    fx_q, fy_q;
   logic [1:0]              tap_q;
   logic signed [CRD_W-1:0] tap_x, tap_y;
   logic                    tap_in;
   logic [FRAC_BITS:0]      wx, wy;
   logic [WU_W-1:0]         w_cur, w_q;
   logic                    acc_en_q;
   logic signed [ACC_W-1:0] pix_ext, w_ext, prod, acc_q, acc_rnd;
   logic signed [RES_W-1:0] res_full;
   logic [PIX_W-1:0]        res_sat;

   assign accept    = (state_q == S_IDLE) && bus.req_valid;
   assign state_dbg = state_q;

   // Integer base moved into the fixed-point domain, then split into floor and fraction.
   assign sum_x = {{(DATA_W-IDX_W-FRAC_BITS){1'b0}}, bus.req_base_x0, {FRAC_BITS{1'b0}}} + bus.req_off_x;
   assign sum_y = {{(DATA_W-IDX_W-FRAC_BITS){1'b0}}, bus.req_base_y0, {FRAC_BITS{1'b0}}} + bus.req_off_y;
   assign int_x = {sum_x[DATA_W-1], sum_x[DATA_W-1:FRAC_BITS]};
   assign int_y = {sum_y[DATA_W-1], sum_y[DATA_W-1:FRAC_BITS]};

`ifdef BSC_ZERO_PAD_EN
   assign base_x = int_x;
   assign base_y = int_y;
`else
   localparam logic signed [CRD_W-1:0] LIM_X = CRD_W'(MAX_X - 2);
   localparam logic signed [CRD_W-1:0] LIM_Y = CRD_W'(MAX_Y - 2);

   // The fraction is kept as-is even when the integer part is clamped.
   always_comb begin
      base_x = int_x;
      if (int_x[CRD_W-1])
         base_x = '0;
      else if (int_x > LIM_X)
         base_x = LIM_X;
      base_y = int_y;
      if (int_y[CRD_W-1])
         base_y = '0;
      else if (int_y > LIM_Y)
         base_y = LIM_Y;
   end
`endif

   // Tap order: t[0] steps x, t[1] steps y.
   assign tap_x  = bx_q + $signed({{(CRD_W-1){1'b0}}, tap_q[0]});
   assign tap_y  = by_q + $signed({{(CRD_W-1){1'b0}}, tap_q[1]});
   assign tap_in = !tap_x[CRD_W-1] && (tap_x <= X_HI) && !tap_y[CRD_W-1] && (tap_y <= Y_HI);

   assign wx    = tap_q[0] ? {1'b0, fx_q} : (S_ONE - {1'b0, fx_q});
   assign wy    = tap_q[1] ? {1'b0, fy_q} : (S_ONE - {1'b0, fy_q});
   assign w_cur = {{(WU_W-FRAC_BITS-1){1'b0}}, wx} * {{(WU_W-FRAC_BITS-1){1'b0}}, wy};

   assign pix_ext = {{(ACC_W-PIX_W){bus.mem_rd_data[PIX_W-1]}}, bus.mem_rd_data};
   assign w_ext   = {{(ACC_W-WU_W){1'b0}}, w_q};
   assign prod    = pix_ext * w_ext;

   assign acc_rnd  = acc_q + RND;
   assign res_full = acc_rnd[ACC_W-1:2*FRAC_BITS];

   always_comb begin
      res_sat = res_full[PIX_W-1:0];
      if (res_full > P_MAX)
         res_sat = P_MAX[PIX_W-1:0];
      else if (res_full < P_MIN)
         res_sat = P_MIN[PIX_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.req_valid) state_d = S_ISSUE;
         S_ISSUE: if (tap_q == 2'd3) state_d = S_DRAIN;
         S_DRAIN: state_d = S_OUT;
         S_OUT:   if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = 1'b0;
      bus.mem_rd_en = 1'b0;
      bus.mem_rd_x  = '0;
      bus.mem_rd_y  = '0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.busy      = 1'b1;
      case (state_q)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            bus.busy      = 1'b0;
         end
         S_ISSUE: begin
            bus.mem_rd_en = tap_in;
            if (tap_in) begin
               bus.mem_rd_x = tap_x[IDX_W-1:0];
               bus.mem_rd_y = tap_y[IDX_W-1:0];
            end
         end
         S_OUT: begin
            bus.out_valid = 1'b1;
            bus.out_data  = res_sat;
         end
         default: ;
      endcase
   end

   // Weight and enable trail the read by one cycle so they meet the returning data.
   always_ff @(posedge clk) begin
      if (rst) begin
         bx_q     <= '0;
         by_q     <= '0;
         fx_q     <= '0;
         fy_q     <= '0;
         tap_q    <= '0;
         w_q      <= '0;
         acc_en_q <= 1'b0;
         acc_q    <= '0;
      end else begin
         acc_en_q <= (state_q == S_ISSUE) && tap_in;
         w_q      <= w_cur;
         if (accept) begin
            bx_q  <= base_x;
            by_q  <= base_y;
            fx_q  <= sum_x[FRAC_BITS-1:0];
            fy_q  <= sum_y[FRAC_BITS-1:0];
            acc_q <= '0;
         end else if (acc_en_q) begin
            acc_q <= acc_q + prod;
         end
         if (state_q == S_ISSUE)
            tap_q <= tap_q + 2'd1;
         else
            tap_q <= '0;
      end
   end
endmodule

// File: tb/tb_bilinear_sample_ctrl.sv
// Self-checking bench for bilinear_sample_ctrl: directed corner cases plus random requests against a reference model.
module tb_bilinear_sample_ctrl;
   localparam int MAX_X = 16;
   localparam int MAX_Y = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state_dbg;
   int         n_tests = 0;
   int         n_fail  = 0;

   logic signed [15:0] mem_arr [0:15][0:15];
   logic [8:0]         rd_q[$];
   logic [15:0]        exp_q[$];

   bilinear_sample_ctrl_if #(.DATA_W(16), .IDX_W(4), .PIX_W(16)) bus ();

   bilinear_sample_ctrl #(
      .DATA_W(16), .FRAC_BITS(8), .IDX_W(4), .MAX_X(MAX_X), .MAX_Y(MAX_Y), .PIX_W(16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   // Tile buffer: one-cycle read latency, noise on the bus when not read.
   always @(posedge clk) begin
      if (bus.mem_rd_en)
         bus.mem_rd_data <= mem_arr[bus.mem_rd_x][bus.mem_rd_y];
      else
         bus.mem_rd_data <= 16'($urandom);
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1);
   end

   task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic fill_ramp();
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            mem_arr[x][y] = 16'(10*x + y);
   endtask

   task automatic fill_const(input logic signed [15:0] v);
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            mem_arr[x][y] = v;
   endtask

   task automatic fill_rand();
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            mem_arr[x][y] = 16'($urandom);
   endtask

   // Reference: floor/fraction split, clamp or zero-pad, weighted sum, round-half-up, saturate.
   task automatic model_req(input int bx0, input int by0, input int offx, input int offy);
      int sx, sy, ix, iy, fx, fy, x, y, w;
      longint acc, r;
      sx = bx0*256 + offx;
      sy = by0*256 + offy;
      ix = sx >>> 8;
      iy = sy >>> 8;
      fx = sx & 255;
      fy = sy & 255;
`ifndef BSC_ZERO_PAD_EN
      ix = (ix < 0) ? 0 : (ix > MAX_X-2) ? MAX_X-2 : ix;
      iy = (iy < 0) ? 0 : (iy > MAX_Y-2) ? MAX_Y-2 : iy;
`endif
      acc = 0;
      for (int k = 0; k < 4; k++) begin
         x = ix + k % 2;
         y = iy + k / 2;
         w = ((k % 2) ? fx : 256 - fx) * ((k / 2) ? fy : 256 - fy);
         if (x >= 0 && x < MAX_X && y >= 0 && y < MAX_Y) begin
            acc += longint'(mem_arr[x][y]) * w;
            rd_q.push_back({1'b1, 4'(x), 4'(y)});
         end else begin
            rd_q.push_back(9'd0);
         end
      end
      r = (acc + 32768) >>> 16;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      exp_q.push_back(16'(r));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, bus.req_ready, 1);
      check({tag, "_rd_en"},     bus.mem_rd_en, 0);
      check({tag, "_rd_x"},      bus.mem_rd_x, 0);
      check({tag, "_rd_y"},      bus.mem_rd_y, 0);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_out_data"},  bus.out_data, 0);
      check({tag, "_busy"},      bus.busy, 0);
   endtask

   task automatic drive_req(input int bx0, input int by0, input int offx, input int offy);
      bus.req_valid   = 1'b1;
      bus.req_base_x0 = 4'(bx0);
      bus.req_base_y0 = 4'(by0);
      bus.req_off_x   = 16'(offx);
      bus.req_off_y   = 16'(offy);
   endtask

   task automatic run_req(input string tag, input int bx0, input int by0,
                          input int offx, input int offy, input int hold);
      logic [8:0]  e;
      logic [15:0] exp_out;
      model_req(bx0, by0, offx, offy);
      @(negedge clk);
      check({tag, "_ready_idle"}, bus.req_ready, 1);
      drive_req(bx0, by0, offx, offy);
      @(negedge clk);
      bus.req_valid   = 1'b0;
      bus.req_off_x   = 16'($urandom);
      bus.req_base_x0 = 4'($urandom);
      for (int t = 0; t < 4; t++) begin
         if (t > 0) @(negedge clk);
         e = rd_q.pop_front();
         check({tag, "_rd_en"}, bus.mem_rd_en, e[8]);
         check({tag, "_rd_x"},  bus.mem_rd_x, e[7:4]);
         check({tag, "_rd_y"},  bus.mem_rd_y, e[3:0]);
         check({tag, "_busy"},  bus.busy, 1);
         check({tag, "_ready_busy"}, bus.req_ready, 0);
      end
      @(negedge clk);
      check({tag, "_drain_valid"}, bus.out_valid, 0);
      check({tag, "_drain_rd_en"}, bus.mem_rd_en, 0);
      @(negedge clk);
      exp_out = exp_q.pop_front();
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) @(negedge clk);
         check({tag, "_out_valid"}, bus.out_valid, 1);
         check({tag, "_out_data"},  $signed(bus.out_data), $signed(exp_out));
         check({tag, "_out_ready"}, bus.req_ready, 0);
         check({tag, "_out_rd_en"}, bus.mem_rd_en, 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "_post_valid"}, bus.out_valid, 0);
      check({tag, "_post_ready"}, bus.req_ready, 1);
      check({tag, "_post_busy"},  bus.busy, 0);
   endtask

   task automatic reset_mid_op();
      @(negedge clk);
      drive_req(3, 5, 128, 64);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst = 1'b0;
   endtask

   initial begin
      rst             = 1'b1;
      bus.req_valid   = 1'b0;
      bus.req_off_x   = '0;
      bus.req_off_y   = '0;
      bus.req_base_x0 = '0;
      bus.req_base_y0 = '0;
      bus.out_ready   = 1'b0;
      fill_ramp();
      repeat (3) @(negedge clk);
      check_reset_outputs("in_rst");
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("after_rst");

      run_req("nominal", 3, 5, 128, 64, 0);
      run_req("neg_clamp", 0, 0, -384, 0, 0);
      run_req("high_clamp", 15, 15, 0, 0, 0);
      run_req("backpressure", 3, 5, 128, 64, 5);
      reset_mid_op();
      run_req("after_midrst", 6, 2, 200, 17, 1);

      fill_const(-16'sd100);
      run_req("neg_pix", 5, 5, 128, 128, 1);
      fill_const(16'sh7FFF);
      run_req("max_pix", 7, 9, 0, 0, 0);
      run_req("max_pix_frac", 4, 4, 77, 201, 0);

      for (int n = 0; n < 40; n++) begin
         if (n % 10 == 0) fill_rand();
         run_req("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                 int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
